// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage definitions: state encoding, instruction field positions and default reset PC.
// Decode and the sign extender import the same field positions.
package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the valid/ready channel towards decode.
interface instruction_fetch_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    import instruction_fetch_stage_pkg::*;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_word;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic [RS_MSB-RS_LSB:0]         rs;
    logic [RT_MSB-RT_LSB:0]         rt;
    logic [IMM_MSB-IMM_LSB:0]       imm16;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output instr_valid, instr_word, instr_pc, opcode, rs, rt, imm16,
        input  instr_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  instr_valid, instr_word, instr_pc, opcode, rs, rt, imm16,
        output instr_ready
    );

endinterface

// File: rtl/instruction_fetch_stage_pc_register.sv
// Program counter: reset value, redirect load and sequential increment (load beats increment).
module pc_register #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(instruction_fetch_stage_pkg::DEFAULT_RESET_PC),
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  incr,
    output logic [ADDR_WIDTH-1:0] pc
);

    // Increment wraps modulo 2^ADDR_WIDTH by truncation.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (incr) begin
            pc <= pc + ADDR_WIDTH'(PC_STEP);
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: one outstanding memory request, instruction register towards decode,
// PC sequencing with branch redirect and halt.
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(instruction_fetch_stage_pkg::DEFAULT_RESET_PC),
    parameter int                    PC_STEP    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        halt,
    input  logic                        branch_taken,
    input  logic [ADDR_WIDTH-1:0]       branch_target,
    instruction_fetch_stage_if.master   bus
);
    import instruction_fetch_stage_pkg::*;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr_word;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  discard;
    logic                  fetch_accept;
    logic [ADDR_WIDTH-1:0] next_fetch_addr;

    assign fetch_accept = (state == REQ) && bus.mem_ack && !discard && !branch_taken;

    // The redirected pc only appears next cycle, so a request issued alongside a redirect uses the target.
    assign next_fetch_addr = branch_taken ? branch_target : pc;

    pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (PC_STEP)
    ) u_pc_register (
        .clock  (clock),
        .reset  (reset),
        .load   (branch_taken),
        .target (branch_target),
        .incr   (fetch_accept),
        .pc     (pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            instr_valid <= 1'b0;
            instr_word  <= '0;
            instr_pc    <= '0;
            discard     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= next_fetch_addr;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        if (discard || branch_taken) begin
                            // Stale response: keep requesting, now at the redirected address.
                            discard  <= 1'b0;
                            mem_addr <= next_fetch_addr;
                        end else begin
                            instr_word  <= bus.mem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            mem_req     <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (branch_taken) begin
                        // The memory handshake cannot be withdrawn; mark its response for dropping.
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_taken || bus.instr_ready) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state <= IDLE;
                        end else begin
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= next_fetch_addr;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_word  = instr_word;
    assign bus.instr_pc    = instr_pc;
    assign bus.opcode      = instr_word[OPCODE_MSB:OPCODE_LSB];
    assign bus.rs          = instr_word[RS_MSB:RS_LSB];
    assign bus.rt          = instr_word[RT_MSB:RT_LSB];
    assign bus.imm16       = instr_word[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: directed scenarios followed by a randomized run
// against a transaction-level model of the fetched instruction stream.
module tb_instruction_fetch_stage;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          halt;
    logic          branch_taken;
    logic [AW-1:0] branch_target;

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    instruction_fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .bus           (bus.master)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Contents of the instruction memory used by the randomized run.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic test_reset();
        reset = 1'b1; halt = 1'b1; branch_taken = 1'b0; branch_target = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.instr_word !== 32'h0) begin errors++; $display("FAIL reset_instr_word: got %h expected 0", bus.instr_word); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", bus.instr_pc); end
    endtask

    task automatic test_basic_fetch();
        reset = 1'b0; halt = 1'b0;
        @(negedge clock);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b expected 1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h expected 0", bus.mem_addr); end
        @(negedge clock);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL basic_req_hold: got req=%b addr=%h expected req=1 addr=0", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2001_FFFC;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.instr_valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b expected 0", bus.mem_req); end
        checks++; if (bus.opcode !== 6'h08) begin errors++; $display("FAIL basic_opcode: got %h expected 08", bus.opcode); end
        checks++; if (bus.rs !== 5'd0) begin errors++; $display("FAIL basic_rs: got %0d expected 0", bus.rs); end
        checks++; if (bus.rt !== 5'd1) begin errors++; $display("FAIL basic_rt: got %0d expected 1", bus.rt); end
        checks++; if (bus.imm16 !== 16'hFFFC) begin errors++; $display("FAIL basic_imm16: got %h expected fffc", bus.imm16); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL basic_instr_pc: got %h expected 0", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        @(negedge clock);
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_accept_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin errors++; $display("FAIL basic_second_req: got req=%b addr=%h expected req=1 addr=4", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        w = $urandom;
        bus.mem_ack = 1'b1; bus.mem_rdata = w;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4) begin errors++; $display("FAIL bp_capture: got valid=%b pc=%h expected valid=1 pc=4", bus.instr_valid, bus.instr_pc); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (bus.instr_word !== w || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_word: got valid=%b word=%h expected valid=1 word=%h", bus.instr_valid, bus.instr_word, w); end
            checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bp_hold_req: got %b expected 0", bus.mem_req); end
        end
        bus.instr_ready = 1'b1;
        @(negedge clock);
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin errors++; $display("FAIL bp_next_req: got req=%b addr=%h expected req=1 addr=8", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_branch_in_req();
        logic [31:0] w;
        branch_taken = 1'b1; branch_target = 32'h100;
        @(negedge clock);
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin errors++; $display("FAIL brreq_old_addr: got req=%b addr=%h expected req=1 addr=8", bus.mem_req, bus.mem_addr); end
            if (i < 2) @(negedge clock);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL brreq_dropped: got valid=%b expected 0", bus.instr_valid); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL brreq_target: got req=%b addr=%h expected req=1 addr=100", bus.mem_req, bus.mem_addr); end
        w = $urandom;
        bus.mem_ack = 1'b1; bus.mem_rdata = w;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr_word !== w) begin errors++; $display("FAIL brreq_fetch: got valid=%b pc=%h word=%h expected valid=1 pc=100 word=%h", bus.instr_valid, bus.instr_pc, bus.instr_word, w); end
    endtask

    task automatic test_branch_with_ready();
        logic [31:0] w;
        bus.instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        @(negedge clock);
        bus.instr_ready = 1'b0; branch_taken = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL brrdy_target: got req=%b addr=%h expected req=1 addr=200", bus.mem_req, bus.mem_addr); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL brrdy_no_valid: got %b expected 0", bus.instr_valid); end
            @(negedge clock);
        end
        w = $urandom;
        bus.mem_ack = 1'b1; bus.mem_rdata = w;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 || bus.instr_word !== w) begin errors++; $display("FAIL brrdy_fetch: got valid=%b pc=%h word=%h expected valid=1 pc=200 word=%h", bus.instr_valid, bus.instr_pc, bus.instr_word, w); end
        bus.instr_ready = 1'b1;
        @(negedge clock);
        bus.instr_ready = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h204) begin errors++; $display("FAIL brrdy_next: got req=%b addr=%h expected req=1 addr=204", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        @(negedge clock);
        bus.mem_ack = 1'b0; branch_taken = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_ack_branch_drop: got valid=%b expected 0", bus.instr_valid); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got req=%b addr=%h expected req=1 addr=fffffffc", bus.mem_req, bus.mem_addr); end
        w = $urandom;
        bus.mem_ack = 1'b1; bus.mem_rdata = w;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch: got valid=%b pc=%h expected valid=1 pc=fffffffc", bus.instr_valid, bus.instr_pc); end
        bus.instr_ready = 1'b1;
        @(negedge clock);
        bus.instr_ready = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got req=%b addr=%h expected req=1 addr=0", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_reset_mid_req();
        reset = 1'b1; halt = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got req=%b valid=%b expected 0 0", bus.mem_req, bus.instr_valid); end
        checks++; if (bus.instr_word !== 32'h0 || bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rstmid_data: got word=%h pc=%h expected 0 0", bus.instr_word, bus.instr_pc); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_halt: got req=%b valid=%b expected 0 0", bus.mem_req, bus.instr_valid); end
        end
        halt = 1'b0;
        @(negedge clock);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_first_req: got req=%b addr=%h expected req=1 addr=0", bus.mem_req, bus.mem_addr); end
    endtask

    // Random memory latency, decode back-pressure, halts and redirects. The model tracks only the
    // architectural instruction stream: each newly presented instruction must sit at the address
    // following the previous one, or at the most recent redirect target if one came in between.
    task automatic test_random();
        logic [31:0] exp_next, prev_word, prev_pc, prev_addr, t, w;
        logic        prev_valid, prev_req, need_new;
        int          wait_cnt, presented;
        reset = 1'b1; halt = 1'b0; branch_taken = 1'b0;
        bus.mem_ack = 1'b0; bus.instr_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_next = 32'h0; prev_valid = 1'b0; prev_req = 1'b0; need_new = 1'b1;
        prev_word = '0; prev_pc = '0; prev_addr = '0; wait_cnt = 0; presented = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            checks++; if (bus.mem_req === 1'b1 && bus.instr_valid === 1'b1) begin errors++; $display("FAIL rnd_overlap: got req=1 valid=1 expected not both at cycle %0d", cyc); end
            if (bus.instr_valid && !prev_valid) begin
                w = mem_word(exp_next);
                presented++;
                checks++; if (bus.instr_pc !== exp_next) begin errors++; $display("FAIL rnd_pc: got %h expected %h at cycle %0d", bus.instr_pc, exp_next, cyc); end
                checks++; if (bus.instr_word !== w) begin errors++; $display("FAIL rnd_word: got %h expected %h at cycle %0d", bus.instr_word, w, cyc); end
                checks++; if (bus.opcode !== w[31:26] || bus.rs !== w[25:21] || bus.rt !== w[20:16] || bus.imm16 !== w[15:0]) begin
                    errors++; $display("FAIL rnd_fields: got %h/%h/%h/%h expected %h/%h/%h/%h", bus.opcode, bus.rs, bus.rt, bus.imm16, w[31:26], w[25:21], w[20:16], w[15:0]);
                end
                exp_next = exp_next + 32'd4;
            end else if (bus.instr_valid) begin
                checks++; if (bus.instr_word !== prev_word || bus.instr_pc !== prev_pc) begin errors++; $display("FAIL rnd_hold_stable: got %h@%h expected %h@%h", bus.instr_word, bus.instr_pc, prev_word, prev_pc); end
            end
            if (bus.mem_req && prev_req && !bus.mem_ack) begin
                checks++; if (bus.mem_addr !== prev_addr) begin errors++; $display("FAIL rnd_addr_stable: got %h expected %h at cycle %0d", bus.mem_addr, prev_addr, cyc); end
            end
            prev_valid = bus.instr_valid; prev_word = bus.instr_word; prev_pc = bus.instr_pc;
            prev_req = bus.mem_req; prev_addr = bus.mem_addr;

            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                if (need_new) begin wait_cnt = $urandom_range(0, 3); need_new = 1'b0; end
                if (wait_cnt == 0) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = mem_word(bus.mem_addr); need_new = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
            bus.instr_ready = ($urandom_range(0, 9) < 6);
            halt = ($urandom_range(0, 9) == 0);
            branch_taken = ($urandom_range(0, 19) == 0);
            if (branch_taken) begin
                t = $urandom; t[1:0] = 2'b00;
                branch_target = t; exp_next = t;
            end
        end
        @(negedge clock);
        bus.mem_ack = 1'b0; bus.instr_ready = 1'b0; branch_taken = 1'b0; halt = 1'b1;
        checks++; if (presented < 100) begin errors++; $display("FAIL rnd_progress: got %0d instructions expected at least 100", presented); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_branch_in_req();
        test_branch_with_ready();
        test_wrap();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Holds each word in an instruction register and presents it to decode with a valid/ready handshake.
- Splits the held word into fields. imm16 drives the 16-bit input of the downstream sign extender directly.
- Owns the PC: sequential increment, branch redirect, halt.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC / memory address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per accepted fetch.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  when high, no new fetch request is started.
- mem_req  out  1  fetch request; held high until mem_ack.
- mem_addr  out  ADDR_WIDTH  fetch address; stable while mem_req is high.
- mem_ack  in  1  memory response strobe; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  fetched word.
- branch_taken  in  1  redirect strobe from execute.
- branch_target  in  ADDR_WIDTH  redirect address.
- instr_valid  out  1  instruction register holds a live instruction.
- instr_ready  in  1  decode accepts the instruction.
- instr_word  out  DATA_WIDTH  held instruction.
- instr_pc  out  ADDR_WIDTH  address of the held instruction.
- opcode  out  6  instr_word[31:26].
- rs  out  5  instr_word[25:21].
- rt  out  5  instr_word[20:16].
- imm16  out  16  instr_word[15:0]; feeds the sign extender.

Behaviour:
- Reset (synchronous, overrides everything, including mid-transaction):
  - pc=RESET_PC; state=IDLE.
  - mem_req=0, instr_valid=0, instr_word=0, instr_pc=0, discard=0.
  - A memory ack arriving during reset is ignored.
- All outputs are registered. Field outputs are pure slices of instr_word.
- State IDLE:
  - halt=0 -> REQ, with mem_req=1 and mem_addr=pc on the next cycle.
  - halt=1 -> stay in IDLE.
- State REQ (mem_req=1):
  - On mem_ack with discard=0: instr_word<=mem_rdata, instr_pc<=pc, pc<=pc+PC_STEP (wraps modulo 2^ADDR_WIDTH), instr_valid<=1, mem_req<=0 -> HOLD.
  - On mem_ack with discard=1: data dropped, discard<=0, mem_req stays 1, mem_addr<=pc (already redirected), stay in REQ.
- State HOLD (instr_valid=1):
  - instr_word, instr_pc and fields are stable until accepted.
  - instr_ready=1 -> instr_valid<=0 -> REQ (halt=0) or IDLE (halt=1).
- Latency:
  - mem_ack in cycle N -> instr_valid=1 in cycle N+1.
  - Acceptance in cycle M -> mem_req=1 in cycle M+1.
  - No fetch overlap: at most one outstanding request.
- Redirect (branch_taken=1) always loads pc<=branch_target, with no increment:
  - In IDLE: next request uses the target.
  - In REQ, same cycle as mem_ack: data dropped, re-request the target next cycle.
  - In REQ, no ack: discard<=1, mem_req stays high at the old address until ack (memory handshake must not be withdrawn). After that ack, re-request the target.
  - In HOLD: instr_valid<=0, instruction dropped, -> REQ (or IDLE if halt).
  - Redirect together with instr_ready in HOLD: redirect wins; the instruction counts as flushed.
- Halt:
  - Never aborts an outstanding request or a held instruction.
  - Only blocks leaving IDLE and the HOLD->REQ transition.
- Back-pressure: instr_ready low in HOLD holds all state indefinitely.
- Invariant: mem_req and instr_valid are never high in the same cycle.

Decomposition:
- Shared package:
  - state enum IDLE/REQ/HOLD.
  - Field bit positions: OPCODE_MSB=31, OPCODE_LSB=26, RS 25:21, RT 20:16, IMM 15:0.
  - Default RESET_PC.
  - These are shared with decode and the sign extender.
- One natural sub-module: pc_register. It holds pc with load (redirect), increment (accepted fetch) and reset. Redirect has priority over increment.

Test Plan:
- Reset then halt=0, memory acks 1 cycle after req with 32'h2001_FFFC:
  - mem_addr=0.
  - instr_valid next cycle, opcode=6'h08, rs=0, rt=1, imm16=16'hFFFC, instr_pc=0.
  - Second request at mem_addr=4.
- instr_ready held low 5 cycles:
  - instr_word unchanged, mem_req=0 throughout.
  - ready=1 -> instr_valid drops, mem_req high next cycle at pc+4.
- branch_taken with target 32'h100 while REQ waits with no ack at addr 8:
  - mem_req stays at 8 until ack; that data never reaches instr_valid.
  - Next mem_addr=32'h100.
- branch_taken and instr_ready together in HOLD:
  - Instruction dropped, next fetch at the target.
  - No instr_valid for the old word after that cycle.
- pc=32'hFFFF_FFFC fetch accepted -> next mem_addr=0 (wrap).
- reset asserted mid-REQ with a simultaneous ack:
  - All outputs return to reset values.
  - First post-reset request at RESET_PC.
  - halt=1 keeps mem_req=0.
